mdc_sched: RTL

MDC_SCHED -- requirements
Module: mdc_sched

---
 rtl/mdc_pkg.sv | 13 +
 rtl/mdc_rr_arb.sv | 29 ++
 rtl/mdc_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/mdc_pkg.sv
// Shared types and default sizing for the round-robin GCD scheduler.
package mdc_pkg;

  localparam int unsigned NReqDefault = 4;
  localparam int unsigned WDefault    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdc_state_e;

endpackage

// File: rtl/mdc_rr_arb.sv
// Combinational round-robin arbiter: first valid request at or above ptr, wrapping to 0.
module mdc_rr_arb #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!gnt_valid && req_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mdc_sched.sv
// GCD engine shared by N_REQ requesters; subtractive Euclid, one step per cycle.
module mdc_sched
  import mdc_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned W     = WDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_x,
  input  logic [N_REQ*W-1:0]       req_y,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_mdc,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  mdc_state_e     state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   result_q, result_d;
  logic [IW-1:0]  id_q, id_d;
  logic [IW-1:0]  ptr_q, ptr_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;

  mdc_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      StIdle: begin
        // A grant from the arbiter is the handshake: it only fires on a valid bit.
        if (gnt_valid) begin
          x_d     = req_x[32'(gnt_idx) * W +: W];
          y_d     = req_y[32'(gnt_idx) * W +: W];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (x_q == '0 || y_q == '0) begin
          result_d = x_q | y_q;
          state_d  = StDone;
        end else if (x_q == y_q) begin
          result_d = x_q;
          state_d  = StDone;
        end else if (x_q < y_q) begin
          y_d = y_q - x_q;
        end else begin
          x_d = x_q - y_q;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle && !rst) ? gnt : '0;
    rsp_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    rsp_id    = id_q;
    rsp_mdc   = result_q;
  end

endmodule
